// File: rtl/id_fetch_queue_pkg.sv
// id_fetch_queue_pkg: RV64I opcode constants, immediate formats and opcode helpers shared by ID logic
package id_fetch_queue_pkg;
  localparam logic [31:0] NOP_INSTR     = 32'h0000_0013;
  localparam logic [6:0]  OPC_LOAD      = 7'b0000011;
  localparam logic [6:0]  OPC_MISC_MEM  = 7'b0001111;
  localparam logic [6:0]  OPC_OP_IMM    = 7'b0010011;
  localparam logic [6:0]  OPC_AUIPC     = 7'b0010111;
  localparam logic [6:0]  OPC_OP_IMM_32 = 7'b0011011;
  localparam logic [6:0]  OPC_STORE     = 7'b0100011;
  localparam logic [6:0]  OPC_OP        = 7'b0110011;
  localparam logic [6:0]  OPC_LUI       = 7'b0110111;
  localparam logic [6:0]  OPC_OP_32     = 7'b0111011;
  localparam logic [6:0]  OPC_BRANCH    = 7'b1100011;
  localparam logic [6:0]  OPC_JALR      = 7'b1100111;
  localparam logic [6:0]  OPC_JAL       = 7'b1101111;
  localparam logic [6:0]  OPC_SYSTEM    = 7'b1110011;

  typedef enum logic [2:0] {FMT_R, FMT_I, FMT_S, FMT_B, FMT_U, FMT_J} imm_fmt_e;

  // Unsupported opcodes map to FMT_R so they carry a zero immediate.
  function automatic imm_fmt_e imm_fmt(input logic [6:0] opc);
    case (opc)
      OPC_LOAD, OPC_OP_IMM, OPC_OP_IMM_32, OPC_JALR, OPC_SYSTEM: return FMT_I;
      OPC_STORE:            return FMT_S;
      OPC_BRANCH:           return FMT_B;
      OPC_LUI, OPC_AUIPC:   return FMT_U;
      OPC_JAL:              return FMT_J;
      default:              return FMT_R;
    endcase
  endfunction

  function automatic logic opc_legal(input logic [6:0] opc);
    case (opc)
      OPC_LOAD, OPC_MISC_MEM, OPC_OP_IMM, OPC_AUIPC, OPC_OP_IMM_32, OPC_STORE, OPC_OP,
      OPC_LUI, OPC_OP_32, OPC_BRANCH, OPC_JALR, OPC_JAL, OPC_SYSTEM: return 1'b1;
      default: return 1'b0;
    endcase
  endfunction
endpackage

// File: rtl/id_fetch_queue_if.sv
// id_fetch_queue_if: IF->ID beat channel {instr, pc} with valid from IF and ready back from ID
//   instr/pc/valid : driven by the IF stage (master)
//   ready          : driven by the ID queue (slave)
interface id_fetch_queue_if;
  logic [31:0] instr;
  logic [63:0] pc;
  logic        valid;
  logic        ready;
  modport master (output instr, pc, valid, input ready);
  modport slave  (input instr, pc, valid, output ready);
endinterface

// File: rtl/id_fetch_queue_instr_predecode.sv
// instr_predecode: combinational RV64I field extraction, immediate generation and class flags
//   instr in; opcode/rd/funct3/rs1/rs2/imm/is_branch/is_jump/illegal out
module instr_predecode
  import id_fetch_queue_pkg::*;
(
  input  logic [31:0] instr,
  output logic [6:0]  opcode,
  output logic [4:0]  rd,
  output logic [2:0]  funct3,
  output logic [4:0]  rs1,
  output logic [4:0]  rs2,
  output logic [63:0] imm,
  output logic        is_branch,
  output logic        is_jump,
  output logic        illegal
);
  imm_fmt_e fmt;
  assign opcode    = instr[6:0];
  assign rd        = instr[11:7];
  assign funct3    = instr[14:12];
  assign rs1       = instr[19:15];
  assign rs2       = instr[24:20];
  assign fmt       = imm_fmt(opcode);
  assign is_branch = opcode == OPC_BRANCH;
  assign is_jump   = opcode == OPC_JAL || opcode == OPC_JALR;
  assign illegal   = !opc_legal(opcode) || instr[1:0] != 2'b11;
  always_comb begin
    imm = '0;
    case (fmt)
      FMT_I:   imm = {{52{instr[31]}}, instr[31:20]};
      FMT_S:   imm = {{52{instr[31]}}, instr[31:25], instr[11:7]};
      FMT_B:   imm = {{51{instr[31]}}, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
      FMT_U:   imm = {{32{instr[31]}}, instr[31:12], 12'b0};
      FMT_J:   imm = {{43{instr[31]}}, instr[31], instr[19:12], instr[20], instr[30:21], 1'b0};
      default: imm = '0;
    endcase
  end
endmodule

// File: rtl/id_fetch_queue.sv
// id_fetch_queue: in-order DEPTH-entry IF->ID beat queue with flush and pre-decoded head
//   clk, rst_n       : clock, asynchronous active-low reset
//   if_bus (slave)   : IF beats {instr, pc, valid}, ready back-pressure
//   i_flush          : EX redirect, empties the queue (highest priority)
//   i_ex_ready       : downstream consumes the head this cycle
//   o_dec_*          : head entry (forced NOP / pc 0 when empty) and its decoded fields
module id_fetch_queue
  import id_fetch_queue_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic               clk,
  input  logic               rst_n,
  id_fetch_queue_if.slave    if_bus,
  input  logic               i_flush,
  input  logic               i_ex_ready,
  output logic               o_dec_valid,
  output logic [31:0]        o_dec_instr,
  output logic [63:0]        o_dec_pc,
  output logic [6:0]         o_opcode,
  output logic [4:0]         o_rd,
  output logic [2:0]         o_funct3,
  output logic [4:0]         o_rs1,
  output logic [4:0]         o_rs2,
  output logic [63:0]        o_imm,
  output logic               o_is_branch,
  output logic               o_is_jump,
  output logic               o_illegal
);
  localparam int PTR_W = $clog2(DEPTH);
  logic [31:0]    instr_q [DEPTH];
  logic [63:0]    pc_q    [DEPTH];
  logic [PTR_W-1:0] wr_ptr, rd_ptr;
  logic [PTR_W:0]   count;
  logic push, pop;
  assign if_bus.ready = count != (PTR_W+1)'(DEPTH);
  assign o_dec_valid  = count != '0;
  assign push = if_bus.valid & if_bus.ready & ~i_flush;
  assign pop  = o_dec_valid & i_ex_ready & ~i_flush;
  assign o_dec_instr  = o_dec_valid ? instr_q[rd_ptr] : NOP_INSTR;
  assign o_dec_pc     = o_dec_valid ? pc_q[rd_ptr] : '0;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        instr_q[i] <= NOP_INSTR;
        pc_q[i]    <= '0;
      end
    end else if (i_flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) begin
        instr_q[wr_ptr] <= if_bus.instr;
        pc_q[wr_ptr]    <= if_bus.pc;
        wr_ptr          <= wr_ptr + PTR_W'(1);
      end
      if (pop) rd_ptr <= rd_ptr + PTR_W'(1);
      count <= count + (PTR_W+1)'(push) - (PTR_W+1)'(pop);
    end
  end
  instr_predecode u_predecode (
    .instr     (o_dec_instr),
    .opcode    (o_opcode),
    .rd        (o_rd),
    .funct3    (o_funct3),
    .rs1       (o_rs1),
    .rs2       (o_rs2),
    .imm       (o_imm),
    .is_branch (o_is_branch),
    .is_jump   (o_is_jump),
    .illegal   (o_illegal)
  );
endmodule

// File: tb/tb_id_fetch_queue.sv
// tb_id_fetch_queue: directed vector table for pre-decode plus hand-written queue sequences
module tb_id_fetch_queue;
  logic clk = 1'b0;
  logic rst_n = 1'b1;
  logic flush = 1'b0;
  logic ex_ready = 1'b0;
  logic        dec_valid, is_branch, is_jump, illegal;
  logic [31:0] dec_instr;
  logic [63:0] dec_pc, imm;
  logic [6:0]  opcode;
  logic [4:0]  rd, rs1, rs2;
  logic [2:0]  funct3;
  int tests = 0;
  int fails = 0;

  id_fetch_queue_if bus();

  id_fetch_queue #(.DEPTH(4)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .if_bus      (bus),
    .i_flush     (flush),
    .i_ex_ready  (ex_ready),
    .o_dec_valid (dec_valid),
    .o_dec_instr (dec_instr),
    .o_dec_pc    (dec_pc),
    .o_opcode    (opcode),
    .o_rd        (rd),
    .o_funct3    (funct3),
    .o_rs1       (rs1),
    .o_rs2       (rs2),
    .o_imm       (imm),
    .o_is_branch (is_branch),
    .o_is_jump   (is_jump),
    .o_illegal   (illegal)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] instr;
    logic [63:0] pc;
    logic [6:0]  opc;
    logic [4:0]  rd;
    logic [2:0]  f3;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [63:0] imm;
    logic        br;
    logic        jmp;
    logic        ill;
  } vec_t;

  vec_t vt[11];

  task automatic chk(input string nm, input logic [255:0] act, input logic [255:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push_one(input logic [63:0] pc);
    bus.valid = 1'b1;
    bus.instr = 32'h0000_0013 | {pc[19:0], 12'h0};
    bus.pc    = pc;
    tick();
    bus.valid = 1'b0;
  endtask

  initial begin
    vt[0]  = '{32'h00500093, 64'h100,  7'h13, 5'd1,  3'd0, 5'd0,  5'd5,  64'd5, 1'b0, 1'b0, 1'b0};
    vt[1]  = '{32'hFE000EE3, 64'h108,  7'h63, 5'h1D, 3'd0, 5'd0,  5'd0,  64'hFFFF_FFFF_FFFF_FFFC, 1'b1, 1'b0, 1'b0};
    vt[2]  = '{32'hFFFFFFFF, 64'h110,  7'h7F, 5'h1F, 3'd7, 5'h1F, 5'h1F, 64'd0, 1'b0, 1'b0, 1'b1};
    vt[3]  = '{32'h123452B7, 64'h118,  7'h37, 5'd5,  3'd5, 5'h08, 5'h03, 64'h0000_0000_1234_5000, 1'b0, 1'b0, 1'b0};
    vt[4]  = '{32'h800000B7, 64'h120,  7'h37, 5'd1,  3'd0, 5'd0,  5'd0,  64'hFFFF_FFFF_8000_0000, 1'b0, 1'b0, 1'b0};
    vt[5]  = '{32'hFF9FF0EF, 64'hFFFF_FFFF_FFFF_FFFC, 7'h6F, 5'd1, 3'd7, 5'h1F, 5'h19, 64'hFFFF_FFFF_FFFF_FFF8, 1'b0, 1'b1, 1'b0};
    vt[6]  = '{32'hFE21B823, 64'h130,  7'h23, 5'h10, 3'd3, 5'd3,  5'd2,  64'hFFFF_FFFF_FFFF_FFF0, 1'b0, 1'b0, 1'b0};
    vt[7]  = '{32'h002081B3, 64'h138,  7'h33, 5'd3,  3'd0, 5'd1,  5'd2,  64'd0, 1'b0, 1'b0, 1'b0};
    vt[8]  = '{32'h00000001, 64'h140,  7'h01, 5'd0,  3'd0, 5'd0,  5'd0,  64'd0, 1'b0, 1'b0, 1'b1};
    vt[9]  = '{32'h00008067, 64'h148,  7'h67, 5'd0,  3'd0, 5'd1,  5'd0,  64'd0, 1'b0, 1'b1, 1'b0};
    vt[10] = '{32'hFFF53283, 64'h150,  7'h03, 5'd5,  3'd3, 5'd10, 5'h1F, 64'hFFFF_FFFF_FFFF_FFFF, 1'b0, 1'b0, 1'b0};

    bus.valid = 1'b0;
    bus.instr = '0;
    bus.pc    = '0;

    // reset asserted mid-cycle takes effect without a clock edge
    #3 rst_n = 1'b0;
    #1;
    chk("reset_ready", bus.ready, 1'b1);
    chk("reset_valid", dec_valid, 1'b0);
    chk("reset_instr", dec_instr, 32'h0000_0013);
    chk("reset_pc", dec_pc, 64'h0);
    chk("reset_imm", imm, 64'h0);
    @(negedge clk) rst_n = 1'b1;
    tick();

    // pre-decode table: push one beat, compare head, pop it
    for (int i = 0; i < 11; i++) begin
      bus.valid = 1'b1;
      bus.instr = vt[i].instr;
      bus.pc    = vt[i].pc;
      ex_ready  = 1'b0;
      tick();
      bus.valid = 1'b0;
      chk($sformatf("vec%0d_head", i),
          {dec_valid, dec_instr, dec_pc, opcode, rd, funct3, rs1, rs2, imm, is_branch, is_jump, illegal},
          {1'b1, vt[i].instr, vt[i].pc, vt[i].opc, vt[i].rd, vt[i].f3, vt[i].rs1, vt[i].rs2,
           vt[i].imm, vt[i].br, vt[i].jmp, vt[i].ill});
      ex_ready = 1'b1;
      tick();
      ex_ready = 1'b0;
      chk($sformatf("vec%0d_popped", i), {dec_valid, dec_instr, opcode}, {1'b0, 32'h0000_0013, 7'h13});
    end

    // fill to DEPTH, hold a 5th beat, then pop once to let it in
    for (int i = 0; i < 4; i++) push_one(64'h100 + 64'(4 * i));
    chk("fill_ready_low", bus.ready, 1'b0);
    bus.valid = 1'b1;
    bus.pc    = 64'h110;
    bus.instr = 32'h0000_0013;
    tick();
    chk("full_hold_ready", bus.ready, 1'b0);
    chk("full_hold_head", dec_pc, 64'h100);
    ex_ready = 1'b1;
    tick();
    chk("pop_frees_ready", bus.ready, 1'b1);
    chk("pop_head", dec_pc, 64'h104);
    ex_ready = 1'b0;
    tick();
    bus.valid = 1'b0;
    chk("fifth_accepted_full", bus.ready, 1'b0);
    ex_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      chk($sformatf("drain%0d_pc", i), {dec_valid, dec_pc}, {1'b1, 64'h104 + 64'(4 * i)});
      tick();
    end
    chk("drain_empty", dec_valid, 1'b0);
    ex_ready = 1'b0;

    // flush with 3 entries while push and pop are both requested
    for (int i = 0; i < 3; i++) push_one(64'h200 + 64'(4 * i));
    bus.valid = 1'b1;
    bus.pc    = 64'h20C;
    ex_ready  = 1'b1;
    flush     = 1'b1;
    tick();
    flush     = 1'b0;
    bus.valid = 1'b0;
    ex_ready  = 1'b0;
    chk("flush_valid", dec_valid, 1'b0);
    chk("flush_ready", bus.ready, 1'b1);
    chk("flush_head", {dec_instr, dec_pc}, {32'h0000_0013, 64'h0});
    push_one(64'h210);
    chk("post_flush_head", {dec_valid, dec_pc}, {1'b1, 64'h210});
    ex_ready = 1'b1;
    tick();
    ex_ready = 1'b0;
    chk("post_flush_single", dec_valid, 1'b0);

    // steady push+pop at count 2 across pointer wrap
    push_one(64'h300);
    push_one(64'h304);
    ex_ready = 1'b1;
    for (int k = 0; k < 6; k++) begin
      bus.valid = 1'b1;
      bus.pc    = 64'h308 + 64'(4 * k);
      tick();
      chk($sformatf("pp%0d_head", k), {dec_valid, bus.ready, dec_pc}, {1'b1, 1'b1, 64'h304 + 64'(4 * k)});
    end
    bus.valid = 1'b0;
    tick();
    chk("pp_tail0", {dec_valid, dec_pc}, {1'b1, 64'h31C});
    tick();
    chk("pp_empty", dec_valid, 1'b0);
    ex_ready = 1'b0;

    // reset mid-operation empties the queue before the next edge
    push_one(64'h400);
    push_one(64'h404);
    chk("pre_reset_head", {dec_valid, dec_pc}, {1'b1, 64'h400});
    #2 rst_n = 1'b0;
    #1;
    chk("midrst_outputs", {bus.ready, dec_valid, dec_instr, dec_pc, imm}, {1'b1, 1'b0, 32'h0000_0013, 64'h0, 64'h0});
    @(negedge clk) rst_n = 1'b1;
    tick();
    chk("after_reset_empty", dec_valid, 1'b0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
